mem_access_unit: RTL and testbench



---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 46 ++++
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-RAM access unit.
package mem_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        BYTE    = 2'd0,
        HALF    = 2'd1,
        WORD    = 2'd2,
        ILLEGAL = 2'd3
    } mem_size_e;

    // FSM encoding kept as plain constants so older code can compare raw bits.
    typedef logic [2:0] mau_state_e;

    localparam mau_state_e IDLE   = 3'd0;
    localparam mau_state_e RD     = 3'd1;
    localparam mau_state_e WR     = 3'd2;
    localparam mau_state_e RMW_RD = 3'd3;
    localparam mau_state_e RMW_WR = 3'd4;
    localparam mau_state_e RESP   = 3'd5;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: load extract/extend and store merge.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  mem_size_e   size,
    input  logic        unsigned_ld,
    output logic [31:0] rdata,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] new_word
);

    logic [4:0]  bit_ofs;
    logic [31:0] shifted;
    logic [31:0] size_mask;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    assign bit_ofs = {lane, 3'b000};

    // Bring the addressed lane down to bit 0 and extend to a full word.
    always_comb begin
        shifted = word >> bit_ofs;
        rdata   = word;
        case (size)
            BYTE:    rdata = {{24{~unsigned_ld & shifted[7]}},  shifted[7:0]};
            HALF:    rdata = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
            default: rdata = word;
        endcase
    end

    // Overlay the right-justified store bytes onto the old word at the lane.
    always_comb begin
        case (size)
            BYTE:    size_mask = {24'h0, 8'hFF};
            HALF:    size_mask = {16'h0, 16'hFFFF};
            default: size_mask = 32'hFFFF_FFFF;
        endcase
        lane_mask = size_mask << bit_ofs;
        lane_data = wdata << bit_ofs;
        new_word  = (old_word & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-RAM initiator: one load/store at a time, word RAM cycles with
// read-modify-write for sub-word stores, single-cycle response pulse.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        read_ram,
    output logic        write_ram,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_out
);

    localparam int          LANE_W = $clog2(WORD_BYTES);
    localparam logic [31:0] DEPTH  = ADDR_WORDS;

    mau_state_e  state;
    mau_state_e  state_nxt;
    logic [1:0]  lane_q;
    mem_size_e   size_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        req_bad;
    logic [31:0] word_idx;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign accept   = req_valid && req_ready;
    assign word_idx = req_addr >> LANE_W;

    // Strobes and handshake decode straight from state so reset drops them at once.
    assign req_ready = (state == IDLE);
    assign read_ram  = (state == RD) || (state == RMW_RD);
    assign write_ram = (state == WR) || (state == RMW_WR);
    assign rsp_valid = (state == RESP);

    // Request legality, in priority order: illegal size, misalignment, range.
    always_comb begin
        req_bad = 1'b0;
        if (req_size == SIZE_ILLEGAL)
            req_bad = 1'b1;
        else if (req_size == SIZE_HALF && req_addr[0])
            req_bad = 1'b1;
        else if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
            req_bad = 1'b1;
        else if (word_idx >= DEPTH)
            req_bad = 1'b1;
    end

    // Both extract and merge work on the word the RAM is presenting this cycle.
    mem_lane_align u_lane_align (
        .word        (ram_out),
        .lane        (lane_q),
        .size        (size_q),
        .unsigned_ld (unsigned_q),
        .rdata       (load_data),
        .old_word    (ram_out),
        .wdata       (wdata_q),
        .new_word    (merged_word)
    );

    // Next-state selection; every RAM phase lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad)
                        state_nxt = RESP;
                    else if (!req_we)
                        state_nxt = RD;
                    else if (req_size == SIZE_WORD)
                        state_nxt = WR;
                    else
                        state_nxt = RMW_RD;
                end
            end
            RD:      state_nxt = RESP;
            WR:      state_nxt = RESP;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Request capture, RAM address/data and response registers. The merged
    // store word is formed from ram_out at the end of RMW_RD and held in
    // ram_write_data, so the captured read word needs no separate register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q         <= 2'd0;
            size_q         <= BYTE;
            unsigned_q     <= 1'b0;
            wdata_q        <= 32'h0;
            ram_addr       <= 32'h0;
            ram_write_data <= 32'h0;
            rsp_rdata      <= 32'h0;
            rsp_err        <= 1'b0;
        end else if (accept) begin
            lane_q     <= req_addr[1:0];
            size_q     <= mem_size_e'(req_size);
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            rsp_rdata  <= 32'h0;
            rsp_err    <= req_bad;
            if (!req_bad)
                ram_addr <= word_idx;
            if (!req_bad && req_we && req_size == SIZE_WORD)
                ram_write_data <= req_wdata;
        end else if (state == RD) begin
            rsp_rdata <= load_data;
        end else if (state == RMW_RD) begin
            ram_write_data <= merged_word;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word RAM and a
// response scoreboard.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        read_ram;
    logic        write_ram;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_out;

    logic [31:0] mem     [0:15];
    logic [31:0] exp_mem [0:15];
    logic [32:0] sb_q [$];
    int          checks;
    int          errors;
    int          last_wait;

    mem_access_unit #(.ADDR_WORDS(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .read_ram       (read_ram),
        .write_ram      (write_ram),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_out        (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: combinational read, write committed in the low phase.
    assign ram_out = (ram_addr < 32'd16) ? mem[ram_addr[3:0]] : 32'h0;
    always @(negedge clk) begin
        if (write_ram && ram_addr < 32'd16)
            mem[ram_addr[3:0]] <= ram_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then follow it to its response.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input logic [31:0] exp_wr_data);
        int waited;
        int lat;
        int nrd;
        int nwr;
        logic [32:0] e;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        waited = 0;
        while (!req_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        sb_q.push_back({exp_err, exp_rdata});
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        nrd = 0;
        nwr = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (read_ram && write_ram)
                chk({tag, "_both_strobes"}, 32'd1, 32'd0);
            if (read_ram) begin
                nrd++;
                chk({tag, "_rd_addr"}, ram_addr, addr >> 2);
            end
            if (write_ram) begin
                nwr++;
                chk({tag, "_wr_addr"}, ram_addr, addr >> 2);
                chk({tag, "_wr_data"}, ram_write_data, exp_wr_data);
            end
            if (rsp_valid) begin
                lat = c;
                if (sb_q.size() == 0) begin
                    chk({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
                    chk({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
                end
            end
        end
        if (lat == 0 && sb_q.size() != 0)
            e = sb_q.pop_front();
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_nread"}, nrd, (!exp_err && (!we || size != 2'd2)) ? 1 : 0);
        chk({tag, "_nwrite"}, nwr, (!exp_err && we) ? 1 : 0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        last_wait    = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_read_ram", 32'(read_ram), 32'd0);
        chk("rst_write_ram", 32'(write_ram), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_write_data, 32'd0);
        rst_n = 1'b1;

        // Preload word i = i through word stores.
        for (int i = 0; i < 16; i++) begin
            do_req("preload", 1'b1, 2'd2, 1'b0, 32'(i * 4), 32'(i), 32'h0, 1'b0, 2, 32'(i));
            exp_mem[i] = 32'(i);
        end

        do_req("ld_word", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h0000_0005, 1'b0, 2, 32'h0);

        do_req("set_w3", 1'b1, 2'd2, 1'b0, 32'h0C, 32'h0000_80FF, 32'h0, 1'b0, 2, 32'h0000_80FF);
        exp_mem[3] = 32'h0000_80FF;
        do_req("set_w2", 1'b1, 2'd2, 1'b0, 32'h08, 32'h1122_3344, 32'h0, 1'b0, 2, 32'h1122_3344);
        exp_mem[2] = 32'h1122_3344;

        do_req("ld_sb",  1'b0, 2'd0, 1'b0, 32'h0D, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 32'h0);
        do_req("ld_ub",  1'b0, 2'd0, 1'b1, 32'h0D, 32'h0, 32'h0000_0080, 1'b0, 2, 32'h0);
        do_req("ld_sh",  1'b0, 2'd1, 1'b0, 32'h0C, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 32'h0);
        do_req("ld_sb0", 1'b0, 2'd0, 1'b0, 32'h0C, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 32'h0);
        do_req("ld_uh2", 1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, 32'h0000_0000, 1'b0, 2, 32'h0);

        do_req("st_byte", 1'b1, 2'd0, 1'b0, 32'h0A, 32'h0000_00AA, 32'h0, 1'b0, 3, 32'h11AA_3344);
        exp_mem[2] = 32'h11AA_3344;
        do_req("st_half", 1'b1, 2'd1, 1'b0, 32'h08, 32'h0000_BEEF, 32'h0, 1'b0, 3, 32'h11AA_BEEF);
        exp_mem[2] = 32'h11AA_BEEF;

        do_req("err_half", 1'b1, 2'd1, 1'b0, 32'h03, 32'h0000_FFFF, 32'h0, 1'b1, 1, 32'h0);
        do_req("err_word", 1'b0, 2'd2, 1'b0, 32'h06, 32'h0,         32'h0, 1'b1, 1, 32'h0);
        do_req("err_size", 1'b1, 2'd3, 1'b0, 32'h10, 32'h5555_5555, 32'h0, 1'b1, 1, 32'h0);
        do_req("err_range", 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b1, 1, 32'h0);

        do_req("b2b_st", 1'b1, 2'd2, 1'b0, 32'h00, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 32'hDEAD_BEEF);
        exp_mem[0] = 32'hDEAD_BEEF;
        do_req("b2b_ld", 1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 32'h0);
        chk("b2b_gap", last_wait, 1);

        for (int i = 0; i < 16; i++)
            chk("ram_contents", mem[i], exp_mem[i]);

        // Reset asserted during the write cycle of a sub-word store.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h04;
        req_wdata = 32'h0000_0077;
        chk("rstw_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstw_read_phase", 32'(read_ram), 32'd1);
        @(negedge clk);
        chk("rstw_write_phase", 32'(write_ram), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_write_drop", 32'(write_ram), 32'd0);
        chk("rstw_read_drop", 32'(read_ram), 32'd0);
        chk("rstw_rsp_drop", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
            chk("rstw_idle", 32'(req_ready), 32'd1);
            @(negedge clk);
        end

        do_req("post_rst_ld", 1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
